// File: rtl/if_stage_if.sv
// Bus bundle between the instruction-fetch stage and its neighbours (hazard unit, decode, EX, imem).
// IF_PERF_CNT_EN adds the stall/flush counter outputs.
interface if_stage_if;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport slave (
    input  stall, PCSrc, jr_target, branch_taken, branch_target, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, OpCode, Funct
`ifdef IF_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport master (
    output stall, PCSrc, jr_target, branch_taken, branch_target, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, OpCode, Funct
`ifdef IF_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds stall/flush event counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect priority: EX branch beats stall; stall freezes ID so PCSrc is moot.
  always_comb begin
    pc_d    = pc_plus4;
    instr_d = bus.imem_data;
    pc4_d   = pc_plus4;
    valid_d = 1'b1;
    if (bus.branch_taken) begin
      pc_d    = {bus.branch_target[31:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (bus.stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (valid_q && bus.PCSrc == 2'b01) begin
      pc_d    = {pc4_q[31:28], instr_q[25:0], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (valid_q && bus.PCSrc == 2'b10) begin
      pc_d    = {bus.jr_target[31:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.OpCode         = instr_q[31:26];
  assign bus.Funct          = instr_q[5:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_ev, flush_ev;

  assign stall_ev = bus.stall && !bus.branch_taken;
  assign flush_ev = bus.branch_taken ||
                    (!bus.stall && valid_q && (bus.PCSrc == 2'b01 || bus.PCSrc == 2'b10));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ev) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the decode-stage control unit. It applies next-PC redirects from the decode-stage jump/`jr` encoding (`PCSrc`) and from taken branches resolved in EX. It also honours the hazard unit's stall and squashes wrong-path fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard unit load-use stall; holds PC and IF/ID.
- `PCSrc`  in  2  from decode control: 00 sequential or branch, 01 `j`/`jal`, 10 `jr`, 11 treated as 00.
- `jr_target`  in  32  forwarded `rs` value for `jr`.
- `branch_taken`  in  1  EX-stage branch resolved taken.
- `branch_target`  in  32  EX-stage branch target.
- `imem_addr`  out  32  equals `pc`; combinational instruction memory.
- `imem_data`  in  32  instruction word at `imem_addr`, same cycle.
- `pc`  out  32  current fetch PC.
- `if_id_instr`  out  32  registered instruction; 0 (`sll $0,$0,0`) when bubble.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `OpCode`  out  6  `if_id_instr[31:26]`.
- `Funct`  out  6  `if_id_instr[5:0]`.

## Operation
- Registered state: `pc`, `if_id_instr`, `if_id_pc_plus4`, `if_id_valid`.
- Next-state priority, highest first:
  - `reset`=0: `pc`=`RESET_PC`, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0.
  - `branch_taken`=1: `pc`=`{branch_target[31:2],2'b00}`. IF/ID is loaded with a bubble (instr 0, valid 0, pc_plus4 0). This overrides `stall` and `PCSrc`.
  - `stall`=1: `pc` and IF/ID hold. `PCSrc` is ignored because the ID instruction is itself held.
  - `if_id_valid`=1 and `PCSrc`=01: `pc`=`{if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}`. IF/ID is loaded with a bubble.
  - `if_id_valid`=1 and `PCSrc`=10: `pc`=`{jr_target[31:2],2'b00}`. IF/ID is loaded with a bubble.
  - Otherwise: `pc`=`pc`+4, wrapping modulo 2^32. IF/ID is loaded with `imem_data`, `pc`+4, and valid 1.
- Target low two bits are always forced to 00; no misalignment exception.
- `PCSrc` is ignored while `if_id_valid`=0, so bubbles never redirect.
- `OpCode`/`Funct` are pure slices of `if_id_instr`; both are 0 for a bubble.

## Timing
- Fetch latency: the word at `pc` in cycle t appears on `if_id_instr` in cycle t+1.
- Jump/`jr` penalty: 1 cycle. A jump in ID at t gives `pc`=target at t+1, and IF/ID is a bubble at t+1.
- Taken-branch penalty from this block: 1 squashed fetch. Squashing the ID-stage instruction is the ID/EX register's responsibility.
- Stall: both PC and IF/ID are frozen for exactly the asserted cycles. There is no internal stall counter.
- `branch_taken` together with `stall` in the same cycle: the redirect wins and IF/ID becomes a bubble.
- Reset asserted mid-stream takes effect at the next edge. All outputs carry their reset values from that edge until the first edge with `reset`=1.
- After reset release: first edge gives `pc`=`RESET_PC`+4 and `if_id_instr`=mem[`RESET_PC`].

## Configuration
- `IF_PERF_CNT_EN` defined: adds outputs `stall_cnt` (out 32) and `flush_cnt` (out 32), both reset to 0.
  - `stall_cnt` increments each cycle that `stall` takes effect, i.e. `stall`=1 and no `branch_taken`.
  - `flush_cnt` increments each cycle a bubble is inserted by `branch_taken`, `PCSrc`=01 or `PCSrc`=10.
  - Both counters wrap at 2^32.
- `IF_PERF_CNT_EN` undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0x0040_0000 and sequential code → `pc`=0x0040_0000, 0x0040_0004, 0x0040_0008. `if_id_instr` lags `imem_data` by one cycle. `if_id_valid` goes 0→1.
- `j` at 0x0040_0008 with index 0x0100040 decoded as `PCSrc`=01 → next `pc`=0x0040_0100. IF/ID is bubble (instr 0, valid 0) for one cycle. The following fetch is mem[0x0040_0100].
- `jr` with `jr_target`=0x0040_0203 → `pc`=0x0040_0200 (low bits cleared). One bubble is inserted.
- `stall` held 2 cycles at `pc`=0x0040_0010 → `pc` and `if_id_instr` are unchanged for 2 cycles, then resume at 0x0040_0014. With `IF_PERF_CNT_EN`, `stall_cnt`=2.
- `branch_taken`=1, `branch_target`=0x0040_0080, with `stall`=1 and `PCSrc`=01 simultaneously → `pc`=0x0040_0080 and IF/ID is a bubble. `flush_cnt` increments by 1 and `stall_cnt` does not.
- `pc`=0xFFFF_FFFC sequential → `pc`=0x0000_0000. Then `reset`=0 for one cycle mid-stream → `pc`=`RESET_PC` and IF/ID is cleared.
